// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, parity modes and frame-size helper for the UART transmit path.
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP} tx_state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD = 2;
  function automatic int frame_bits(input int dw, input int par, input int sb);
    return 1 + dw + ((par != PARITY_NONE) ? 1 : 0) + sb;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: baud counter that pulses o_tick on the last clock of every bit period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q;
  assign o_tick = !i_clr && (cnt_q == W'(CLKS_PER_BIT - 1));
  always_ff @(posedge i_clk)
    cnt_q <= (i_rst || i_clr || o_tick) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the byte FIFO one word at a time and serializes each word as a UART frame.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  output logic                  o_fifo_read,
  output logic                  o_tx,
  output logic                  o_busy
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam bit HAS_PAR = PARITY != PARITY_NONE;
  tx_state_t state_q, state_d;
  logic tx_q, tx_d, par_q, par_d, tick;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  wire fetch_ok = i_enable && !i_fifo_empty;
  wire last_data = bit_q == BW'(DATA_WIDTH - 1);
  wire last_stop = bit_q == BW'(STOP_BITS - 1);
  // Counter is held at zero until the start bit so every frame begins on a full bit period.
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (state_q inside {S_IDLE, S_FETCH, S_LOAD}),
    .o_tick(tick)
  );
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    sh_d = sh_q;
    bit_d = bit_q;
    par_d = par_q;
    case (state_q)
      S_IDLE: state_d = fetch_ok ? S_FETCH : S_IDLE;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        sh_d = i_fifo_rdata;
        par_d = (^i_fifo_rdata) ^ (PARITY == PARITY_ODD);
        tx_d = 1'b0;
        bit_d = '0;
        state_d = S_START;
      end
      S_START: if (tick) begin
        tx_d = sh_q[0];
        sh_d = sh_q >> 1;
        state_d = S_DATA;
      end
      S_DATA: if (tick) begin
        bit_d = last_data ? '0 : bit_q + 1'b1;
        tx_d = last_data ? (HAS_PAR ? par_q : 1'b1) : sh_q[0];
        sh_d = last_data ? sh_q : sh_q >> 1;
        state_d = !last_data ? S_DATA : HAS_PAR ? S_PARITY : S_STOP;
      end
      S_PARITY: if (tick) begin
        tx_d = 1'b1;
        state_d = S_STOP;
      end
      S_STOP: if (tick) begin
        bit_d = last_stop ? '0 : bit_q + 1'b1;
        state_d = !last_stop ? S_STOP : fetch_ok ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      tx_q <= 1'b1;
      sh_q <= '0;
      bit_q <= '0;
      par_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      par_q <= par_d;
    end
  end
  assign o_tx = tx_q;
  assign o_fifo_read = state_q == S_FETCH;
  assign o_busy = state_q != S_IDLE;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three transmitters (no/even/odd parity) fed by queue-based FIFO models, checked against expected line waveforms.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [2:0] empty = 3'b111;
  logic [7:0] rdata [3];
  logic [7:0] q0[$], q1[$], q2[$];
  int reads[3];
  int total = 0, bad = 0;
  wire tx0, tx1, tx2, rd0, rd1, rd2, bz0, bz1, bz2;
  wire [2:0] tx = {tx2, tx1, tx0};
  wire [2:0] rd = {rd2, rd1, rd0};
  wire [2:0] busy = {bz2, bz1, bz0};
  always #5 clk = ~clk;
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_fifo_empty(empty[0]), .i_fifo_rdata(rdata[0]),
    .o_fifo_read(rd0), .o_tx(tx0), .o_busy(bz0));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_fifo_empty(empty[1]), .i_fifo_rdata(rdata[1]),
    .o_fifo_read(rd1), .o_tx(tx1), .o_busy(bz1));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_fifo_empty(empty[2]), .i_fifo_rdata(rdata[2]),
    .o_fifo_read(rd2), .o_tx(tx2), .o_busy(bz2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One clock: a read strobe seen before the edge delivers the head word just after it.
  task automatic tick();
    logic [2:0] p;
    p = rd;
    @(posedge clk);
    #1;
    if (p[0]) begin reads[0]++; if (q0.size() != 0) rdata[0] = q0.pop_front(); end
    if (p[1]) begin reads[1]++; if (q1.size() != 0) rdata[1] = q1.pop_front(); end
    if (p[2]) begin reads[2]++; if (q2.size() != 0) rdata[2] = q2.pop_front(); end
    @(negedge clk);
    empty = {q2.size() == 0, q1.size() == 0, q0.size() == 0};
  endtask
  task automatic push(input int k, input logic [7:0] d);
    if (k == 0) q0.push_back(d);
    else if (k == 1) q1.push_back(d);
    else q2.push_back(d);
    empty[k] = 1'b0;
  endtask
  task automatic check_frame(input int k, input logic [7:0] d, input int exp_wait, input bit exp_idle, input int drop_at);
    bit bits[$];
    int n = 0;
    int idx = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (k != 0) bits.push_back((($countones(d) % 2) == 1) ^ (k == 2));
    bits.push_back(1'b1);
    while (!rd[k] && n < 60) begin tick(); n++; end
    chk("read_seen", {31'd0, rd[k]}, 1);
    if (exp_wait >= 0) chk("fetch_wait", n, exp_wait);
    chk("busy_fetch", {31'd0, busy[k]}, 1);
    tick();
    chk("read_pulse_len", {31'd0, rd[k]}, 0);
    chk("tx_load", {31'd0, tx[k]}, 1);
    tick();
    foreach (bits[b]) for (int c = 0; c < CPB; c++) begin
      if (idx == drop_at) en = 1'b0;
      chk($sformatf("tx_k%0d_bit%0d", k, b), {31'd0, tx[k]}, {31'd0, bits[b]});
      chk("busy_frame", {31'd0, busy[k]}, 1);
      tick();
      idx++;
    end
    if (exp_idle) begin
      chk("idle_busy", {31'd0, busy[k]}, 0);
      chk("idle_tx", {31'd0, tx[k]}, 1);
    end
  endtask
  initial begin
    logic [7:0] w[4];
    logic [7:0] r;
    int n;
    rdata[0] = '0; rdata[1] = '0; rdata[2] = '0;
    push(0, 8'hA5);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_tx", {31'd0, tx[0]}, 1);
      chk("rst_read", {31'd0, rd[0]}, 0);
      chk("rst_busy", {31'd0, busy[0]}, 0);
    end
    rst = 1'b0;
    check_frame(0, 8'hA5, 1, 1, -1);
    chk("reads_a5", reads[0], 1);
    r = 8'($urandom);
    push(1, 8'h07); push(1, r);
    check_frame(1, 8'h07, 1, 0, -1);
    check_frame(1, r, 0, 1, -1);
    r = 8'($urandom);
    push(2, 8'h07); push(2, r);
    check_frame(2, 8'h07, 1, 0, -1);
    check_frame(2, r, 0, 1, -1);
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    check_frame(0, 8'h11, 1, 0, -1);
    check_frame(0, 8'h22, 0, 0, -1);
    check_frame(0, 8'h33, 0, 1, -1);
    chk("reads_b2b", reads[0], 4);
    for (int i = 0; i < 4; i++) begin w[i] = 8'($urandom); push(0, w[i]); end
    for (int i = 0; i < 4; i++) check_frame(0, w[i], (i == 0) ? 1 : 0, i == 3, -1);
    push(0, 8'h44); push(0, 8'h00);
    check_frame(0, 8'h44, 1, 1, 8);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("disabled_read", {31'd0, rd[0]}, 0);
    end
    chk("disabled_left", q0.size(), 1);
    en = 1'b1;
    n = 0;
    while (!rd[0] && n < 10) begin tick(); n++; end
    chk("zero_read_seen", {31'd0, rd[0]}, 1);
    repeat (8) tick();
    chk("pre_rst_tx", {31'd0, tx[0]}, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx", {31'd0, tx[0]}, 1);
    chk("mid_rst_busy", {31'd0, busy[0]}, 0);
    chk("mid_rst_read", {31'd0, rd[0]}, 0);
    tick();
    chk("mid_rst_read2", {31'd0, rd[0]}, 0);
    push(0, 8'h3C);
    rst = 1'b0;
    check_frame(0, 8'h3C, 1, 1, -1);
    chk("reads0_total", reads[0], 11);
    chk("reads1_total", reads[1], 2);
    chk("reads2_total", reads[2], 2);
    chk("fifo0_drained", q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
